vga_layer_arbiter: RTL and testbench

VGA_LAYER_ARBITER -- requirements
Module: vga_layer_arbiter

---
 rtl/vga_pkg.sv | 19 +
 rtl/vga_cfg_shadow.sv | 55 +++++
 rtl/vga_layer_arbiter.sv | 105 ++++++++++
 tb/tb_vga_layer_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants, configuration record and config FSM encoding for the VGA layer arbiter.
package vga_pkg;

  localparam int          RGB_W   = 3;
  localparam int          LAYER_N = 3;
  localparam logic [1:0]  BG_CODE = 2'd3;

  typedef enum logic [0:0] {
    CFG_IDLE    = 1'b0,
    CFG_PENDING = 1'b1
  } cfg_state_e;

  typedef struct packed {
    logic [LAYER_N-1:0] en;
    logic [RGB_W-1:0]   bg;
    logic               blink;
  } cfg_t;

endpackage

// File: rtl/vga_cfg_shadow.sv
// Double-buffered layer configuration: writes are held pending and only become
// active on a frame start, so a frame never sees a mid-frame change.
module vga_cfg_shadow
  import vga_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_start_i,
  input  logic       cfg_wr_i,
  input  cfg_t       cfg_i,
  output cfg_t       act_o,
  output cfg_state_e state_o
);

  localparam cfg_t CFG_RESET = '{en: 3'b001, bg: '0, blink: 1'b0};

  cfg_state_e state_q, state_d;
  cfg_t       pnd_q, pnd_d;
  cfg_t       act_q, act_d;
  logic       load;
  logic       apply;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= CFG_IDLE;
      pnd_q   <= CFG_RESET;
      act_q   <= CFG_RESET;
    end else begin
      state_q <= state_d;
      pnd_q   <= pnd_d;
      act_q   <= act_d;
    end
  end

  // A write that lands on a frame start is only captured; it applies one frame later.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CFG_IDLE:    if (cfg_wr_i)      state_d = CFG_PENDING;
      CFG_PENDING: if (frame_start_i) state_d = CFG_IDLE;
      default:                        state_d = CFG_IDLE;
    endcase
  end

  always_comb begin
    load  = (state_q == CFG_IDLE) && cfg_wr_i;
    apply = (state_q == CFG_PENDING) && frame_start_i;
    pnd_d = load  ? cfg_i : pnd_q;
    act_d = apply ? pnd_q : act_q;
    // Forward the applying value so pixel (0,0) already uses the new setup.
    act_o   = act_d;
    state_o = state_q;
  end

endmodule

// File: rtl/vga_layer_arbiter.sv
// Three-layer fixed-priority pixel arbiter with blink on layer 2, registered
// outputs on the pixel tick and frame-synchronous configuration updates.
module vga_layer_arbiter
  import vga_pkg::*;
#(
  parameter int FRAME_W   = 6,
  parameter int BLINK_BIT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pixel_tick,
  input  logic                       video_on,
  input  logic [9:0]                 pixel_x,
  input  logic [9:0]                 pixel_y,
  input  logic                       h_sync_in,
  input  logic                       v_sync_in,
  input  logic [LAYER_N-1:0]         layer_on,
  input  logic [LAYER_N*RGB_W-1:0]   layer_rgb,
  input  logic                       cfg_wr,
  input  logic [LAYER_N-1:0]         cfg_en,
  input  logic [RGB_W-1:0]           cfg_bg,
  input  logic                       cfg_blink,
  output logic                       cfg_busy,
  output logic [RGB_W-1:0]           rgb,
  output logic                       hsync,
  output logic                       vsync,
  output logic [1:0]                 active_layer,
  output logic [FRAME_W-1:0]         frame_cnt
);

  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [RGB_W-1:0]   rgb_q, rgb_d;
  logic [1:0]         layer_q, layer_d;
  logic               hsync_q, vsync_q;
  logic [LAYER_N-1:0] elig;
  logic               blink_off;
  cfg_t               cfg_req;
  cfg_t               act;
  cfg_state_e         cfg_state;

  assign frame_start = pixel_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);
  assign cfg_req     = '{en: cfg_en, bg: cfg_bg, blink: cfg_blink};

  vga_cfg_shadow u_cfg_shadow (
    .clk_i         (clk),
    .reset_i       (reset),
    .frame_start_i (frame_start),
    .cfg_wr_i      (cfg_wr),
    .cfg_i         (cfg_req),
    .act_o         (act),
    .state_o       (cfg_state)
  );

  assign cfg_busy = (cfg_state == CFG_PENDING);

  // Pixel (0,0) belongs to the new frame, so blink phase uses the advanced count.
  always_comb begin
    frame_cnt_d = frame_start ? frame_cnt_q + FRAME_W'(1) : frame_cnt_q;
    blink_off   = act.blink && frame_cnt_d[BLINK_BIT];
    elig[0]     = layer_on[0] && act.en[0];
    elig[1]     = layer_on[1] && act.en[1];
    elig[2]     = layer_on[2] && act.en[2] && !blink_off;
  end

  always_comb begin
    layer_d = BG_CODE;
    rgb_d   = act.bg;
    if (elig[2]) begin
      layer_d = 2'd2;
      rgb_d   = layer_rgb[2*RGB_W +: RGB_W];
    end else if (elig[1]) begin
      layer_d = 2'd1;
      rgb_d   = layer_rgb[1*RGB_W +: RGB_W];
    end else if (elig[0]) begin
      layer_d = 2'd0;
      rgb_d   = layer_rgb[0 +: RGB_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      rgb_q       <= '0;
      layer_q     <= BG_CODE;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      if (pixel_tick) begin
        rgb_q   <= video_on ? rgb_d : '0;
        layer_q <= layer_d;
        hsync_q <= h_sync_in;
        vsync_q <= v_sync_in;
      end
    end
  end

  assign rgb          = rgb_q;
  assign active_layer = layer_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_vga_layer_arbiter.sv
// Directed bench for vga_layer_arbiter: priority, blink, shadowed config and reset.
module tb_vga_layer_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pixel_tick = 1'b0;
  logic       video_on = 1'b0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic       h_sync_in = 1'b0;
  logic       v_sync_in = 1'b0;
  logic [2:0] layer_on = '0;
  logic [8:0] layer_rgb = '0;
  logic       cfg_wr = 1'b0;
  logic [2:0] cfg_en = '0;
  logic [2:0] cfg_bg = '0;
  logic       cfg_blink = 1'b0;
  logic       cfg_busy;
  logic [2:0] rgb;
  logic       hsync;
  logic       vsync;
  logic [1:0] active_layer;
  logic [5:0] frame_cnt;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [5:0] exp_fc  = '0;

  vga_layer_arbiter #(.FRAME_W(6), .BLINK_BIT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_tick   (pixel_tick),
    .video_on     (video_on),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .h_sync_in    (h_sync_in),
    .v_sync_in    (v_sync_in),
    .layer_on     (layer_on),
    .layer_rgb    (layer_rgb),
    .cfg_wr       (cfg_wr),
    .cfg_en       (cfg_en),
    .cfg_bg       (cfg_bg),
    .cfg_blink    (cfg_blink),
    .cfg_busy     (cfg_busy),
    .rgb          (rgb),
    .hsync        (hsync),
    .vsync        (vsync),
    .active_layer (active_layer),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_tick(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    pixel_tick = 1'b1;
    pixel_x    = x;
    pixel_y    = y;
    @(posedge clk);
    #1;
    pixel_tick = 1'b0;
    if (x == 10'd0 && y == 10'd0) exp_fc = exp_fc + 6'd1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] en, input logic [2:0] bg, input logic blink);
    @(negedge clk);
    cfg_wr    = 1'b1;
    cfg_en    = en;
    cfg_bg    = bg;
    cfg_blink = blink;
    @(posedge clk);
    #1;
    cfg_wr = 1'b0;
  endtask

  // Reset is held across a tick at the frame origin with syncs high: reset must win.
  task automatic pulse_reset(input logic with_tick);
    @(negedge clk);
    reset      = 1'b1;
    pixel_tick = with_tick;
    pixel_x    = '0;
    pixel_y    = '0;
    h_sync_in  = 1'b1;
    v_sync_in  = 1'b1;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    pixel_tick = 1'b0;
    h_sync_in  = 1'b0;
    v_sync_in  = 1'b0;
    exp_fc     = '0;
  endtask

  initial begin
    layer_rgb = 9'b100_010_001;

    pulse_reset(1'b1);
    check("rst_rgb", rgb, 3'b000);
    check("rst_layer", active_layer, 2'd3);
    check("rst_fc", frame_cnt, 6'd0);
    check("rst_hsync", hsync, 1'b0);
    check("rst_vsync", vsync, 1'b0);
    check("rst_busy", cfg_busy, 1'b0);

    video_on = 1'b1; layer_on = 3'b000; h_sync_in = 1'b1;
    do_tick(10'd5, 10'd5);
    check("idle_rgb", rgb, 3'b000);
    check("idle_layer", active_layer, 2'd3);
    check("idle_fc", frame_cnt, 6'd0);
    check("idle_hsync", hsync, 1'b1);
    check("idle_vsync", vsync, 1'b0);

    layer_on = 3'b011;
    do_tick(10'd6, 10'd5);
    check("dflt_l0_rgb", rgb, 3'b001);
    check("dflt_l0_layer", active_layer, 2'd0);
    layer_on = 3'b110;
    do_tick(10'd7, 10'd5);
    check("dflt_bg_layer", active_layer, 2'd3);

    cfg_write(3'b111, 3'b000, 1'b0);
    check("en_busy", cfg_busy, 1'b1);
    layer_on = 3'b111; h_sync_in = 1'b0; v_sync_in = 1'b1;
    do_tick(10'd0, 10'd0);
    check("prio_l2_rgb", rgb, 3'b100);
    check("prio_l2_layer", active_layer, 2'd2);
    check("en_busy_clr", cfg_busy, 1'b0);
    check("fc_1", frame_cnt, exp_fc);
    check("sync_h", hsync, 1'b0);
    check("sync_v", vsync, 1'b1);
    layer_on = 3'b011;
    do_tick(10'd1, 10'd0);
    check("prio_l1_rgb", rgb, 3'b010);
    check("prio_l1_layer", active_layer, 2'd1);
    layer_on = 3'b001;
    do_tick(10'd2, 10'd0);
    check("prio_l0_rgb", rgb, 3'b001);
    video_on = 1'b0; layer_on = 3'b011;
    do_tick(10'd3, 10'd0);
    check("blank_rgb", rgb, 3'b000);
    check("blank_layer", active_layer, 2'd1);

    video_on = 1'b1; layer_on = 3'b100; v_sync_in = 1'b0;
    idle_cycles(3);
    check("hold_layer", active_layer, 2'd1);
    check("hold_vsync", vsync, 1'b1);

    cfg_write(3'b111, 3'b101, 1'b0);
    check("shadow_busy", cfg_busy, 1'b1);
    cfg_write(3'b111, 3'b011, 1'b0);
    check("wbusy_busy", cfg_busy, 1'b1);
    layer_on = 3'b000;
    do_tick(10'd3, 10'd3);
    check("shadow_old_bg", rgb, 3'b000);
    check("shadow_old_layer", active_layer, 2'd3);
    do_tick(10'd0, 10'd0);
    check("shadow_new_bg", rgb, 3'b101);
    check("shadow_busy_clr", cfg_busy, 1'b0);
    check("fc_2", frame_cnt, exp_fc);
    do_tick(10'd1, 10'd1);
    check("shadow_keep_bg", rgb, 3'b101);

    cfg_en = 3'b111; cfg_bg = 3'b110; cfg_blink = 1'b0; cfg_wr = 1'b1;
    do_tick(10'd0, 10'd0);
    cfg_wr = 1'b0;
    check("fsw_capture_rgb", rgb, 3'b101);
    check("fsw_busy", cfg_busy, 1'b1);
    do_tick(10'd2, 10'd0);
    check("fsw_mid_rgb", rgb, 3'b101);
    do_tick(10'd0, 10'd0);
    check("fsw_apply_rgb", rgb, 3'b110);
    check("fsw_busy_clr", cfg_busy, 1'b0);
    check("fc_4", frame_cnt, exp_fc);

    cfg_write(3'b111, 3'b000, 1'b1);
    layer_on = 3'b100;
    do_tick(10'd0, 10'd0);
    check("blink_f5_layer", active_layer, 2'd2);
    check("blink_f5_rgb", rgb, 3'b100);
    for (int i = 0; i < 60; i++) begin
      do_tick(10'd0, 10'd0);
      check("blink_fc", frame_cnt, exp_fc);
      check("blink_org_layer", active_layer, exp_fc[4] ? 2'd3 : 2'd2);
      do_tick(10'd9, 10'd9);
      check("blink_mid_rgb", rgb, exp_fc[4] ? 3'b000 : 3'b100);
    end
    check("wrap_fc", frame_cnt, 6'd1);

    cfg_write(3'b111, 3'b111, 1'b0);
    check("rmid_busy", cfg_busy, 1'b1);
    pulse_reset(1'b0);
    check("rmid_busy_clr", cfg_busy, 1'b0);
    check("rmid_rgb", rgb, 3'b000);
    check("rmid_layer", active_layer, 2'd3);
    check("rmid_fc", frame_cnt, 6'd0);
    layer_on = 3'b000;
    do_tick(10'd0, 10'd0);
    check("rmid_bg", rgb, 3'b000);
    check("rmid_busy_after", cfg_busy, 1'b0);
    check("rmid_fc1", frame_cnt, 6'd1);
    layer_on = 3'b010;
    do_tick(10'd4, 10'd4);
    check("rmid_en_layer", active_layer, 2'd3);
    layer_on = 3'b001;
    do_tick(10'd5, 10'd4);
    check("rmid_l0_rgb", rgb, 3'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
